aes_key_expand_128: RTL and testbench

Iterative AES-128 key expansion engine. It accepts a 128-bit cipher key over a valid/ready handshake and produces the 11 round keys (rounds 0..10), one per clock. Each round key comes with its round index and a valid strobe. It sits directly downstream of the round-constant generator: it drives that stage's `kld` and consumes its 32-bit `out` as the `rcon` input. The cipher and inverse-cipher datapaths consume the round keys it produces.

---
 rtl/aes_pkg.sv | 13 +
 rtl/aes_sbox.sv | 28 ++
 rtl/aes_key_expand_128.sv | 148 ++++++++++++++
 tb/tb_aes_key_expand_128.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, round count and word helpers.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_key_t;

  localparam int AES128_ROUNDS = 10;

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (table lookup).
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y_o = SBOX[a_i];

endmodule

// File: rtl/aes_key_expand_128.sv
// Iterative AES-128 key schedule, one round key per clock.
// AES_KEY_STORE_EN adds an 11-entry round-key store with a read port.
module aes_key_expand_128
  import aes_pkg::*;
#(
  parameter int ROUNDS = AES128_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_vld,
  output logic         key_rdy,
  output logic         kld,
  input  logic [31:0]  rcon,
  output logic [127:0] rk,
  output logic         rk_vld,
  output logic [3:0]   rk_rnd,
  output logic         busy,
`ifdef AES_KEY_STORE_EN
  input  logic [3:0]   rd_rnd,
  output logic [127:0] rd_key,
  output logic         store_vld,
`endif
  output logic         done
);

  typedef enum logic {
    IDLE,
    EXP
  } state_e;

  localparam logic [3:0] LAST = 4'(ROUNDS);

  state_e    state_q, state_d;
  aes_key_t  rk_q, rk_d;
  logic      rk_vld_q, rk_vld_d;
  logic [3:0] rk_rnd_q, rk_rnd_d;

  aes_word_t w0, w1, w2, w3;
  aes_word_t rot, sub, t;
  aes_word_t n0, n1, n2, n3;
  logic      last;
  logic      unused_rcon;

  assign w0 = rk_q[127:96];
  assign w1 = rk_q[95:64];
  assign w2 = rk_q[63:32];
  assign w3 = rk_q[31:0];

  assign rot = rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (rot[8*i +: 8]),
      .y_o (sub[8*i +: 8])
    );
  end

  // Only the top byte of the upstream rcon word carries the constant.
  assign t           = sub ^ {rcon[31:24], 24'h0};
  assign unused_rcon = ^rcon[23:0];

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign last = (state_q == EXP) && (rk_rnd_q == LAST);

  always_comb begin
    state_d  = state_q;
    rk_d     = rk_q;
    rk_vld_d = rk_vld_q;
    rk_rnd_d = rk_rnd_q;
    key_rdy  = (state_q == IDLE);
    busy     = (state_q == EXP);
    kld      = key_vld & key_rdy;
    done     = last;
    unique case (state_q)
      IDLE: begin
        rk_vld_d = 1'b0;
        if (kld) begin
          state_d  = EXP;
          rk_d     = key_in;
          rk_rnd_d = 4'd0;
          rk_vld_d = 1'b1;
        end
      end
      EXP: begin
        if (last) begin
          state_d  = IDLE;
          rk_vld_d = 1'b0;
        end else begin
          rk_d     = {n0, n1, n2, n3};
          rk_rnd_d = rk_rnd_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rk_q     <= '0;
      rk_vld_q <= 1'b0;
      rk_rnd_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      rk_q     <= rk_d;
      rk_vld_q <= rk_vld_d;
      rk_rnd_q <= rk_rnd_d;
    end
  end

  assign rk     = rk_q;
  assign rk_vld = rk_vld_q;
  assign rk_rnd = rk_rnd_q;

`ifdef AES_KEY_STORE_EN
  aes_key_t store_q [0:ROUNDS];
  aes_key_t rd_key_q;
  logic     store_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= ROUNDS; i++) begin
        store_q[i] <= '0;
      end
      store_vld_q <= 1'b0;
      rd_key_q    <= '0;
    end else begin
      if (rk_vld_q) begin
        store_q[rk_rnd_q] <= rk_q;
      end
      if (kld) begin
        store_vld_q <= 1'b0;
      end else if (done) begin
        store_vld_q <= 1'b1;
      end
      rd_key_q <= (rd_rnd <= LAST) ? store_q[rd_rnd] : '0;
    end
  end

  assign rd_key    = rd_key_q;
  assign store_vld = store_vld_q;
`endif

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Self-checking bench: directed and random keys vs a FIPS-197 word-level model.
module tb_aes_key_expand_128;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_vld = 1'b0;
  logic         key_rdy, kld;
  logic [31:0]  rcon;
  logic [127:0] rk;
  logic         rk_vld;
  logic [3:0]   rk_rnd;
  logic         busy, done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_rnd = 4'd0;
  logic [127:0] rd_key;
  logic         store_vld;
`endif

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_rk [0:10];
  logic [127:0] cap    [0:10];
  logic [7:0]   rc_q;

  aes_key_expand_128 dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_vld   (key_vld),
    .key_rdy   (key_rdy),
    .kld       (kld),
    .rcon      (rcon),
    .rk        (rk),
    .rk_vld    (rk_vld),
    .rk_rnd    (rk_rnd),
    .busy      (busy),
`ifdef AES_KEY_STORE_EN
    .rd_rnd    (rd_rnd),
    .rd_key    (rd_key),
    .store_vld (store_vld),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-box from its definition: GF(2^8) inverse then the affine map.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] s = x;
    logic [7:0] r = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    if (x == 8'h00) r = 8'h00;
    return r ^ rl(r, 1) ^ rl(r, 2) ^ rl(r, 3) ^ rl(r, 4) ^ 8'h63;
  endfunction

  task automatic model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Upstream round-constant stage.
  always @(posedge clk or negedge rst) begin
    if (!rst) rc_q <= 8'h00;
    else if (kld) rc_q <= 8'h01;
    else rc_q <= xt(rc_q);
  end
  assign rcon = {rc_q, 24'h0};

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] rnd_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Caller is just past a negedge; this cycle is the handshake (cycle 0).
  // mode 0: plain, 1: key_vld held high, 2: foreign key pulsed in cycles 3..5.
  task automatic run_key(input logic [127:0] key, input int mode);
    logic pulse;
    model(key);
    key_in  = key;
    key_vld = 1'b1;
    #1;
    chk1("rdy_c0", key_rdy, 1'b1);
    chk1("kld_c0", kld, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      pulse   = (mode == 2) && (c >= 3) && (c <= 5);
      key_vld = (mode == 1) || pulse;
      key_in  = pulse ? ~key : key;
      #1;
      cap[c-1] = rk;
      chkw($sformatf("rk_r%0d", c-1), rk, exp_rk[c-1]);
      chkw("rk_rnd", 128'(rk_rnd), 128'(c-1));
      chk1("rk_vld", rk_vld, 1'b1);
      chk1($sformatf("done_c%0d", c), done, c == 11);
      chk1("busy", busy, 1'b1);
      chk1("key_rdy_exp", key_rdy, 1'b0);
      chk1("kld_exp", kld, 1'b0);
`ifdef AES_KEY_STORE_EN
      if (c == 1) chk1("store_clr", store_vld, 1'b0);
`endif
    end
    @(negedge clk);
    key_vld = (mode == 1);
    #1;
    chk1("rk_vld_c12", rk_vld, 1'b0);
    chkw("rk_hold_c12", rk, exp_rk[10]);
    chk1("rdy_c12", key_rdy, 1'b1);
    chk1("busy_c12", busy, 1'b0);
    chk1("done_c12", done, 1'b0);
    chk1("kld_c12", kld, mode == 1);
`ifdef AES_KEY_STORE_EN
    chk1("store_set", store_vld, 1'b1);
`endif
  endtask

  initial begin
    rst = 1'b0;
    #1;
    chkw("rst_rk", rk, 128'h0);
    chk1("rst_vld", rk_vld, 1'b0);
    chkw("rst_rnd", 128'(rk_rnd), 128'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("rel_rdy", key_rdy, 1'b1);
    chk1("rel_kld", kld, 1'b0);
`ifdef AES_KEY_STORE_EN
    chk1("rel_store", store_vld, 1'b0);
`endif

    @(negedge clk);
    run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
    chkw("fips_r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chkw("fips_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KEY_STORE_EN
    for (int r = 10; r >= 0; r--) begin
      rd_rnd = 4'(r);
      @(negedge clk);
      #1;
      chkw($sformatf("store_rd%0d", r), rd_key, cap[r]);
    end
    rd_rnd = 4'd12;
    @(negedge clk);
    #1;
    chkw("store_rd12", rd_key, 128'h0);
`endif

    @(negedge clk);
    run_key(128'h0, 0);
    chkw("zero_r1", cap[1], 128'h62636363626363636263636362636363);
    chkw("zero_r10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    @(negedge clk);
    run_key(rnd_key(), 1);
    run_key(rnd_key(), 0);

    @(negedge clk);
    run_key(rnd_key(), 2);

    @(negedge clk);
    key_in  = rnd_key();
    key_vld = 1'b1;
    @(negedge clk);
    key_vld = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chkw("abort_rk", rk, 128'h0);
    chk1("abort_vld", rk_vld, 1'b0);
    chkw("abort_rnd", 128'(rk_rnd), 128'h0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
`ifdef AES_KEY_STORE_EN
    chk1("abort_store", store_vld, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("abort_rdy", key_rdy, 1'b1);
    @(negedge clk);
    run_key(rnd_key(), 0);

    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      run_key(rnd_key(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
